// File: rtl/sweeper_pkg.sv
// Shared state encoding and hold-timer sizing helpers for truth_table_sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int HOLD_MIN = 2;
    localparam int HOLD_MAX = 255;

    function automatic bit hold_cycles_legal(input int hold);
        return (hold >= HOLD_MIN) && (hold <= HOLD_MAX);
    endfunction

    function automatic int hold_cnt_width(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// hold_timer: counts the cycles a stimulus vector has been held and flags the last one.
module hold_timer
    import sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = hold_cnt_width(HOLD_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic last
);

    logic [CNT_W-1:0] hold_cnt;

    assign last = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (clear || last) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 2**N_IN input vectors into a logic block and
// captures its f/g outputs as truth tables. Optional checking via `SWEEP_COMPARE_EN.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int                     N_IN        = 4,
    parameter int                     HOLD_CYCLES = 20,
    parameter logic [(1<<N_IN)-1:0]   EXP_F       = '0,
    parameter logic [(1<<N_IN)-1:0]   EXP_G       = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    input  logic                   g_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   tt_f,
    output logic [(1<<N_IN)-1:0]   tt_g,
    output logic                   mismatch,
    output logic [N_IN-1:0]        fail_idx
);

    if (!hold_cycles_legal(HOLD_CYCLES)) begin : g_bad_hold
        $error("truth_table_sweeper: HOLD_CYCLES must be within 2..255");
    end

    state_t state;
    logic   hold_last;
    logic   start_ok;
    logic   sample;

    assign start_ok = start && !abort && (state != ST_DRIVE);
    assign sample   = !abort && (state == ST_DRIVE) && hold_last;

    // Timer is held at zero outside DRIVE, so the first DRIVE cycle counts as hold 0.
    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state != ST_DRIVE) || abort),
        .last  (hold_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tt_f    <= '0;
            tt_g    <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state   <= ST_DRIVE;
                        vec_out <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        tt_f    <= '0;
                        tt_g    <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (sample) begin
                        tt_f[vec_out] <= f_in;
                        tt_g[vec_out] <= g_in;
                        if (&vec_out) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SWEEP_COMPARE_EN
    // Sticky first-failure capture; survives abort, cleared only by a new sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else if (start_ok) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else if (sample && !mismatch &&
                     ((f_in != EXP_F[vec_out]) || (g_in != EXP_G[vec_out]))) begin
            mismatch <= 1'b1;
            fail_idx <= vec_out;
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^{EXP_F, EXP_G};
    assign mismatch   = 1'b0;
    assign fail_idx   = '0;
`endif

endmodule
